// File: rtl/iq_txd_serializer_if.sv
// AXI-Stream word channel feeding the IQ symbol serializer.
// master drives data/valid/last; slave returns ready.
interface iq_txd_serializer_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/iq_txd_serializer.sv
// AXI-Stream to IQ symbol serializer: FIFO, symbol-rate divider, shifter.
// Optional per-frame preamble enabled by defining IQ_TXD_PREAMBLE_EN.
module iq_txd_serializer #(
   parameter int                DATA_W    = 32,
   parameter int                LANES     = 2,
   parameter int                DEPTH     = 8,
   parameter int                DIV       = 3,
   parameter bit                MSB_FIRST = 1'b1,
   parameter logic [LANES-1:0]  IDLE_SYM  = '0,
   parameter logic [DATA_W-1:0] PREAMBLE  = 32'hAAAA_AAAA
) (
   input  logic               clk100,
   input  logic               reset,
   iq_txd_serializer_if.slave s_axis,
   output logic [LANES-1:0]   iq_txd,
   output logic               sym_strobe,
   output logic               tx_busy,
   output logic               frame_done,
   output logic               underrun
);

   localparam int SYMS = DATA_W / LANES;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW   = (SYMS > 1) ? $clog2(SYMS) : 1;

   if ((DATA_W % LANES) != 0 || DEPTH < 2 ||
       (DEPTH & (DEPTH - 1)) != 0 || DIV < 1 ||
       $bits(PREAMBLE) != DATA_W) begin : g_bad_cfg
      $error("iq_txd_serializer: unsupported parameters");
   end

`ifdef IQ_TXD_PREAMBLE_EN
   typedef enum logic [1:0] {IDLE, SHIFT, STALL, PRE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, STALL} state_t;
`endif

   function automatic logic [LANES-1:0] head_sym(
      input logic [DATA_W-1:0] w
   );
      return MSB_FIRST ? w[DATA_W-1 -: LANES] : w[LANES-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] drop_sym(
      input logic [DATA_W-1:0] w
   );
      return MSB_FIRST ? (w << LANES) : (w >> LANES);
   endfunction

   logic [DATA_W:0]   mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [DATA_W:0]   head;
   logic              live;
   logic              push;
   logic              pop;
   logic              empty;
   logic              full;

   logic [CW-1:0]     cnt;

   state_t            state;
   state_t            state_n;
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] sh_n;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     idx_n;
   logic              last_q;
   logic              last_n;
   logic [LANES-1:0]  iq_n;
   logic              fd_n;
   logic              ur_n;
   logic              sym_end;
   logic              step;
   logic              load;
   logic              begin_frame;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];
   assign push  = s_axis.tvalid && s_axis.tready;
   assign s_axis.tready = live && !full;

   assign sym_strobe = (cnt == CW'(DIV - 1));
   assign sym_end    = (idx == IW'(SYMS - 1));
   assign tx_busy    = (state != IDLE);

   // Ready stays low through reset and rises the cycle after it.
   always_ff @(posedge clk100) begin
      if (reset) live <= 1'b0;
      else       live <= 1'b1;
   end

   // Word storage; contents are dead once the pointers are cleared.
   always_ff @(posedge clk100) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
   end

   // FIFO pointers carry a wrap bit to tell full from empty.
   always_ff @(posedge clk100) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + (AW + 1)'(push);
         rd_ptr <= rd_ptr + (AW + 1)'(pop);
      end
   end

   // Free-running symbol divider; its wrap cycle is the strobe.
   always_ff @(posedge clk100) begin
      if (reset)           cnt <= '0;
      else if (sym_strobe) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
   end

   // Next symbol, shifter and frame state, evaluated on strobes only.
   always_comb begin
      state_n     = state;
      sh_n        = sh;
      idx_n       = idx;
      last_n      = last_q;
      iq_n        = iq_txd;
      fd_n        = 1'b0;
      ur_n        = 1'b0;
      pop         = 1'b0;
      step        = 1'b0;
      load        = 1'b0;
      begin_frame = 1'b0;
      if (sym_strobe) begin
         unique case (state)
            IDLE: begin
               if (!empty) begin_frame = 1'b1;
            end
            SHIFT: begin
               if (!sym_end) begin
                  step = 1'b1;
               end else if (last_q) begin
                  fd_n = 1'b1;
                  if (!empty) begin
                     begin_frame = 1'b1;
                  end else begin
                     iq_n    = IDLE_SYM;
                     state_n = IDLE;
                  end
               end else if (!empty) begin
                  load = 1'b1;
               end else begin
                  ur_n    = 1'b1;
                  iq_n    = IDLE_SYM;
                  state_n = STALL;
               end
            end
            STALL: begin
               if (!empty) load = 1'b1;
            end
`ifdef IQ_TXD_PREAMBLE_EN
            PRE: begin
               if (!sym_end) step = 1'b1;
               else          load = 1'b1;
            end
`endif
            default: state_n = IDLE;
         endcase
      end
`ifdef IQ_TXD_PREAMBLE_EN
      if (begin_frame) begin
         iq_n    = head_sym(PREAMBLE);
         sh_n    = drop_sym(PREAMBLE);
         idx_n   = '0;
         state_n = PRE;
      end
`else
      if (begin_frame) load = 1'b1;
`endif
      if (step) begin
         iq_n  = head_sym(sh);
         sh_n  = drop_sym(sh);
         idx_n = idx + IW'(1);
      end
      if (load) begin
         pop     = 1'b1;
         iq_n    = head_sym(head[DATA_W-1:0]);
         sh_n    = drop_sym(head[DATA_W-1:0]);
         idx_n   = '0;
         last_n  = head[DATA_W];
         state_n = SHIFT;
      end
   end

   // Registered state, shifter, symbol output and one-cycle pulses.
   always_ff @(posedge clk100) begin
      if (reset) begin
         state      <= IDLE;
         sh         <= '0;
         idx        <= '0;
         last_q     <= 1'b0;
         iq_txd     <= IDLE_SYM;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_n;
         sh         <= sh_n;
         idx        <= idx_n;
         last_q     <= last_n;
         iq_txd     <= iq_n;
         frame_done <= fd_n;
         underrun   <= ur_n;
      end
   end

endmodule
